// File: rtl/posit_random_source_pkg.sv
// PositRandomPkg: shared LFSR constants, state type and single-step helper for the posit random source.
package PositRandomPkg;
  typedef logic [31:0] lfsr_t;
  localparam lfsr_t LFSR_MASK = 32'h8020_0003;
  localparam lfsr_t DEFAULT_SEED = 32'hACE1_2468;
  typedef enum logic {WARMUP, RUN} state_e;
  function automatic lfsr_t lfsr_step(input lfsr_t s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction
endpackage

// File: rtl/posit_random_source_if.sv
// posit_random_source_if: seed load plus valid/ready draw channel of the posit random source.
interface posit_random_source_if #(parameter int OUT_BITS = 9);
  logic                seedValid;
  logic [31:0]         seed;
  logic                outValid;
  logic                outReady;
  logic [OUT_BITS-1:0] outBits;
  logic [31:0]         drawCount;
  modport master(input seedValid, seed, outReady, output outValid, outBits, drawCount);
  modport slave(output seedValid, seed, outReady, input outValid, outBits, drawCount);
endinterface

// File: rtl/posit_random_source_lfsr.sv
// LfsrAdvance: combinational STEPS-step Galois LFSR advance; bits[k] is the lsb shifted out at step k.
module LfsrAdvance
  import PositRandomPkg::*;
#(
  parameter int STEPS = 9
) (
  input  lfsr_t             state,
  output lfsr_t             nextState,
  output logic [STEPS-1:0]  bits
);
  lfsr_t chain [STEPS+1];
  assign chain[0] = state;
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    assign bits[i]       = chain[i][0];
    assign chain[i+1]    = lfsr_step(chain[i]);
  end
  assign nextState = chain[STEPS];
endmodule

// File: rtl/posit_random_source.sv
// posit_random_source: LFSR draw generator with warm-up, reseed and valid/ready output for the stochastic rounder.
module posit_random_source
  import PositRandomPkg::*;
#(
  parameter int TRAILING_BITS = 8,
  parameter int OUT_BITS      = TRAILING_BITS + 1,
  parameter int WARMUP_CYCLES = 16
) (
  input logic clock,
  input logic reset,
  posit_random_source_if.master bus
);
  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES);
  lfsr_t               lfsr_q, lfsr_d, adv_state;
  state_e              state_q, state_d;
  logic [7:0]          warm_cnt_q, warm_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_bits_q, out_bits_d, adv_bits;
  logic [31:0]         draw_count_q, draw_count_d;

  LfsrAdvance #(.STEPS(OUT_BITS)) u_adv (
    .state    (lfsr_q),
    .nextState(adv_state),
    .bits     (adv_bits)
  );

  // Reseed wins over everything; a coincident handshake is simply dropped from the count.
  always_comb begin
    lfsr_d       = lfsr_q;
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    out_valid_d  = out_valid_q;
    out_bits_d   = out_bits_q;
    draw_count_d = draw_count_q;
    if (bus.seedValid) begin
      lfsr_d       = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
      state_d      = WARMUP;
      warm_cnt_d   = '0;
      out_valid_d  = 1'b0;
      draw_count_d = '0;
    end else if (state_q == WARMUP) begin
      lfsr_d     = adv_state;
      warm_cnt_d = warm_cnt_q + 8'd1;
      if (warm_cnt_q == WARM_LAST) begin
        out_bits_d  = adv_bits;
        out_valid_d = 1'b1;
        state_d     = RUN;
      end
    end else if (out_valid_q && bus.outReady) begin
      lfsr_d       = adv_state;
      out_bits_d   = adv_bits;
      draw_count_d = draw_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q       <= DEFAULT_SEED;
      state_q      <= WARMUP;
      warm_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_bits_q   <= '0;
      draw_count_q <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      out_valid_q  <= out_valid_d;
      out_bits_q   <= out_bits_d;
      draw_count_q <= draw_count_d;
    end
  end

  assign bus.outValid  = out_valid_q;
  assign bus.outBits   = out_bits_q;
  assign bus.drawCount = draw_count_q;
endmodule

// File: tb/tb_posit_random_source.sv
// tb_posit_random_source: directed and randomized checks of posit_random_source against a bit-serial LFSR model.
module tb_posit_random_source;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  posit_random_source_if #(.OUT_BITS(9)) bus ();
  posit_random_source_if #(.OUT_BITS(9)) bus0 ();

  posit_random_source dut (.clock(clock), .reset(reset), .bus(bus.master));
  posit_random_source #(.WARMUP_CYCLES(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0.master));

  assign bus0.seedValid = bus.seedValid;
  assign bus0.seed      = bus.seed;
  assign bus0.outReady  = bus.outReady;

  int total = 0;
  int bad = 0;
  logic [31:0] ms;
  logic [8:0]  exp_bits;
  int          exp_cnt;
  int          ups, n, cyc;
  logic [8:0]  r;
  logic        hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_draw(output logic [8:0] d);
    d = '0;
    for (int k = 0; k < 9; k++) begin
      d[k] = ms[0];
      ms = (ms >> 1) ^ (ms[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  task automatic model_seed(input logic [31:0] s);
    logic [8:0] junk;
    ms = (s == 32'h0) ? 32'hACE1_2468 : s;
    repeat (16) model_draw(junk);
    exp_cnt = 0;
  endtask

  task automatic warm(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      check({tag, "_valid_low"}, 32'(bus.outValid), 32'd0);
    end
    tick();
    check({tag, "_valid_rise"}, 32'(bus.outValid), 32'd1);
    model_draw(exp_bits);
    check({tag, "_first_draw"}, 32'(bus.outBits), 32'(exp_bits));
    check({tag, "_count0"}, bus.drawCount, 32'd0);
  endtask

  task automatic run(input string tag, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      tick();
      exp_cnt++;
      model_draw(exp_bits);
      check({tag, "_draw"}, 32'(bus.outBits), 32'(exp_bits));
    end
    check({tag, "_count"}, bus.drawCount, 32'(exp_cnt));
  endtask

  initial begin
    bus.seedValid = 1'b0;
    bus.seed      = '0;
    bus.outReady  = 1'b1;
    #1;
    check("rst_valid", 32'(bus.outValid), 32'd0);
    check("rst_bits", 32'(bus.outBits), 32'd0);
    check("rst_count", bus.drawCount, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    model_seed(32'h0);
    warm("power_up");
    check("warm0_valid", 32'(bus0.outValid), 32'd1);
    check("warm0_bits", 32'(bus0.outBits), 32'(exp_bits));
    check("warm0_count", bus0.drawCount, 32'd16);
    run("free_run", 64);
    check("free_run_64", bus.drawCount, 32'd64);

    bus.seedValid = 1'b1;
    bus.seed      = 32'h0;
    tick();
    bus.seedValid = 1'b0;
    check("zseed_valid", 32'(bus.outValid), 32'd0);
    check("zseed_count", bus.drawCount, 32'd0);
    model_seed(32'h0);
    warm("zero_seed");
    run("zero_seed", 20);

    bus.outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_bits", 32'(bus.outBits), 32'(exp_bits));
      check("stall_count", bus.drawCount, 32'(exp_cnt));
      check("stall_valid", 32'(bus.outValid), 32'd1);
    end
    bus.outReady = 1'b1;
    run("stall_release", 5);

    bus.seedValid = 1'b1;
    bus.seed      = 32'h1;
    tick();
    bus.seedValid = 1'b0;
    check("seed1_valid", 32'(bus.outValid), 32'd0);
    check("seed1_count", bus.drawCount, 32'd0);
    model_seed(32'h1);
    warm("seed1");
    run("seed1", 8);

    bus.seedValid = 1'b1;
    bus.seed      = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("seed_hold_valid", 32'(bus.outValid), 32'd0);
    end
    bus.seedValid = 1'b0;
    model_seed(32'h1234_5678);
    warm("seed_hold");
    run("seed_hold", 4);

    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.outValid), 32'd0);
    check("midrst_bits", 32'(bus.outBits), 32'd0);
    check("midrst_count", bus.drawCount, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    model_seed(32'h0);
    warm("after_reset");
    run("after_reset", 10);

    ups = 0;
    n   = 0;
    cyc = 0;
    while (n < 1000 && cyc < 5000) begin
      bus.outReady = ($urandom_range(3) != 0);
      hs = bus.outValid && bus.outReady;
      r  = bus.outBits;
      tick();
      cyc++;
      if (hs) begin
        n++;
        exp_cnt++;
        if (128 + int'(r) >= 512) ups++;
        model_draw(exp_bits);
        check("rand_draw", 32'(bus.outBits), 32'(exp_bits));
      end else begin
        check("rand_hold", 32'(bus.outBits), 32'(exp_bits));
      end
    end
    check("rand_transfers", 32'(n), 32'd1000);
    check("rand_count", bus.drawCount, 32'(exp_cnt));
    $display("rounded to 65 in %0d of %0d draws", ups, n);
    check("round65_range", 32'(ups >= 200 && ups <= 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/posit_random_source.md
# posit_random_source

Pseudo-random bit source that feeds the `randomBits` input of the stochastic posit rounder. It produces one fresh, non-overlapping draw of `TRAILING_BITS+1` bits per accepted transfer, using a 32-bit Galois LFSR advanced `OUT_BITS` steps per draw. It sits directly upstream of the rounding stage and supports run-time reseeding, a warm-up period, and a valid/ready handshake so the rounder's pipeline can stall it.

## Interface
Parameters:
- `TRAILING_BITS`, default 8: trailing-bit width of the downstream rounder.
- `OUT_BITS`, default `TRAILING_BITS+1`: bits per draw; legal range 1..32.
- `WARMUP_CYCLES`, default 16: advance cycles discarded after reset or reseed; legal range 0..255.

Ports:
- `clock`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `seedValid`, input, 1: load `seed` this cycle.
- `seed`, input, 32: new LFSR state.
- `outValid`, output, 1: `outBits` holds an unconsumed draw.
- `outReady`, input, 1: the consumer accepts `outBits` this cycle.
- `outBits`, output, `OUT_BITS`: random draw.
- `drawCount`, output, 32: number of completed transfers since reset or reseed; wraps at 2^32.

## Operation
- LFSR uses the Galois polynomial x^32+x^22+x^2+x+1, taps mask `32'h8020_0003`, and shifts right.
  - One step: `lsb = s[0]`; `s = (s >> 1) ^ (lsb ? mask : 0)`; the output bit is `lsb`.
- A draw advances the LFSR `OUT_BITS` steps in a single cycle. Output bit k is the step-k `lsb`, step 0 first, mapped to `outBits[k]`.
- State 0 is illegal. Any seed of 0 is replaced by `DEFAULT_SEED = 32'hACE1_2468`.
- The FSM has two states: `WARMUP` and `RUN`.
  - **WARMUP:** every cycle advances the LFSR by one draw and increments `warmCnt`. When `warmCnt == WARMUP_CYCLES`, that edge loads a draw into `outBits`, sets `outValid=1`, and moves to `RUN`. With `WARMUP_CYCLES=0`, the first edge loads the draw.
  - **RUN:** if `outValid && outReady`, the next edge loads a new draw into `outBits` and increments `drawCount`. `outValid` stays 1, so there is no bubble and one draw is delivered per cycle at full throughput.
  - **RUN stall:** if `!outReady`, `outBits`, the LFSR and `drawCount` hold.
- Reseed: `seedValid` has priority in any state.
  - Next edge: LFSR is loaded with `seed` (or `DEFAULT_SEED` if `seed` is 0), `warmCnt=0`, `drawCount=0`, `outValid=0`, FSM goes to `WARMUP`.
  - A handshake coinciding with `seedValid` counts as consumed by the consumer, but does not increment `drawCount`.
  - `seedValid` held high keeps reloading the seed and holds the block in `WARMUP`.
- Reset values: LFSR = `DEFAULT_SEED`, FSM = `WARMUP`, `warmCnt=0`, `outValid=0`, `outBits=0`, `drawCount=0`.
- Reset asserted mid-operation returns all of the above immediately (asynchronously). The block then behaves exactly as after power-up.

## Timing
- All outputs are registered. No combinational path exists from `outReady` or `seedValid` to any output.
- `outValid` first rises after `WARMUP_CYCLES+1` rising edges following reset release or the reseed edge.
- Handshake latency: a transfer at edge N presents the new `outBits` after edge N.
- `outBits` is stable while `outValid && !outReady`.
- `drawCount` updates on the same edge as the transfer.

## Structure
- Shared package `PositRandomPkg`: `LFSR_MASK`, `DEFAULT_SEED`, the `lfsr_t` typedef (32-bit), and the FSM enum.
- Sub-module `LfsrAdvance`: combinational, parameter `STEPS`. Inputs `state`; outputs `nextState` and `bits[STEPS-1:0]`, built from unrolled single steps.
- The top level holds the FSM, the counters and the output register. It instantiates `LfsrAdvance #(OUT_BITS)` once.

## Test plan
- **Reset then free-run:** hold `outReady=1`, default parameters. Expect `outValid` to rise after 17 edges, then 64 consecutive draws that match the bench's bit-serial LFSR model. Expect `drawCount=64`.
- **Zero seed:** pulse `seedValid` with `seed=0`. Expect the sequence to be identical to the post-reset sequence, and `outValid=0` for 17 edges.
- **Stall:** drop `outReady=0` for 10 cycles with `outValid=1`. Expect `outBits` and `drawCount` unchanged. On release, the next draw equals the model's next value, with no draw skipped.
- **Reseed coincident with a transfer:** `seedValid=1`, `seed=32'h1`, `outReady=1`, `outValid=1`.
  - Expect `drawCount=0` and `outValid=0` next cycle.
  - Expect the first post-warm-up draw to equal the model's output seeded from 1.
- **Reset mid-RUN:** assert `reset` low between edges. Expect `outValid=0`, `outBits=0` and `drawCount=0` immediately. After release, the sequence equals the post-power-up sequence.
- **Integration with the rounder:**
  - Setup: 1000 draws into a WIDTH=8, ES=1 rounder, with input posit 64, trailing bits `8'b01000000`, sticky 0.
  - Expect the rounded output to equal 65 in 200..300 cases.
